// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key decoder: scan codes, key codes,
// receiver states and the scan-code to key-code lookup.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;

  localparam logic [7:0] SC_0       = 8'h45;
  localparam logic [7:0] SC_KP0     = 8'h70;
  localparam logic [7:0] SC_1       = 8'h16;
  localparam logic [7:0] SC_KP1     = 8'h69;
  localparam logic [7:0] SC_2       = 8'h1E;
  localparam logic [7:0] SC_KP2     = 8'h72;
  localparam logic [7:0] SC_3       = 8'h26;
  localparam logic [7:0] SC_KP3     = 8'h7A;
  localparam logic [7:0] SC_4       = 8'h25;
  localparam logic [7:0] SC_KP4     = 8'h6B;
  localparam logic [7:0] SC_5       = 8'h2E;
  localparam logic [7:0] SC_KP5     = 8'h73;
  localparam logic [7:0] SC_6       = 8'h36;
  localparam logic [7:0] SC_KP6     = 8'h74;
  localparam logic [7:0] SC_7       = 8'h3D;
  localparam logic [7:0] SC_KP7     = 8'h6C;
  localparam logic [7:0] SC_8       = 8'h3E;
  localparam logic [7:0] SC_KP8     = 8'h75;
  localparam logic [7:0] SC_9       = 8'h46;
  localparam logic [7:0] SC_KP9     = 8'h7D;
  localparam logic [7:0] SC_KP_ADD  = 8'h79;
  localparam logic [7:0] SC_MINUS   = 8'h4E;
  localparam logic [7:0] SC_KP_SUB  = 8'h7B;
  localparam logic [7:0] SC_KP_MUL  = 8'h7C;
  localparam logic [7:0] SC_KP_DIV  = 8'h4A;
  localparam logic [7:0] SC_ENTER   = 8'h5A;

  localparam logic [10:0] KEY_ADD   = 11'd10;
  localparam logic [10:0] KEY_SUB   = 11'd11;
  localparam logic [10:0] KEY_MUL   = 11'd12;
  localparam logic [10:0] KEY_DIV   = 11'd13;
  localparam logic [10:0] KEY_ENTER = 11'd14;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef struct packed {
    logic        hit;
    logic [10:0] code;
  } key_lookup_t;

  function automatic key_lookup_t key_lookup(input logic [7:0] sc);
    key_lookup_t r;
    r.hit  = 1'b1;
    r.code = 11'd0;
    case (sc)
      SC_0, SC_KP0:        r.code = 11'd0;
      SC_1, SC_KP1:        r.code = 11'd1;
      SC_2, SC_KP2:        r.code = 11'd2;
      SC_3, SC_KP3:        r.code = 11'd3;
      SC_4, SC_KP4:        r.code = 11'd4;
      SC_5, SC_KP5:        r.code = 11'd5;
      SC_6, SC_KP6:        r.code = 11'd6;
      SC_7, SC_KP7:        r.code = 11'd7;
      SC_8, SC_KP8:        r.code = 11'd8;
      SC_9, SC_KP9:        r.code = 11'd9;
      SC_KP_ADD:           r.code = KEY_ADD;
      SC_MINUS, SC_KP_SUB: r.code = KEY_SUB;
      SC_KP_MUL:           r.code = KEY_MUL;
      SC_KP_DIV:           r.code = KEY_DIV;
      SC_ENTER:            r.code = KEY_ENTER;
      default:             r.hit  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Keyboard-side PS/2 lines plus the key strobe bus towards the sequencer.
interface ps2_key_decoder_if;

  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] data_out;
  logic        sel;
  logic        frame_err;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output data_out,
    output sel,
    output frame_err
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  data_out,
    input  sel,
    input  frame_err
  );

endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronisers, falling-edge detect, frame FSM,
// inactivity timeout and odd-parity / stop-bit validation.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_prev;
  logic          fe;
  logic          data_s;

  rx_state_t     state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          valid_n, err_n;

  // Both lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fe     = clk_prev & ~clk_sync[1];
  assign data_s = data_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'd0;
      par        <= 1'b0;
      tmo        <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      par        <= par_n;
      tmo        <= tmo_n;
      byte_valid <= valid_n;
      frame_err  <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    tmo_n     = '0;

    case (state)
      RX_IDLE: begin
        if (fe && !data_s) begin
          state_n   = RX_DATA;
          bit_cnt_n = 3'd0;
        end
      end
      RX_DATA: begin
        if (fe) begin
          shift_n   = {data_s, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (fe) begin
          par_n   = data_s;
          state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fe) begin
          if (data_s && (^{shift, par})) valid_n = 1'b1;
          else                            err_n   = 1'b1;
          state_n = RX_IDLE;
        end
      end
      default: state_n = RX_IDLE;
    endcase

    // A stalled keyboard mid-frame is dropped without flagging an error.
    if (state != RX_IDLE && !fe) begin
      tmo_n = tmo + TW'(1);
      if (tmo_n == TW'(TIMEOUT_CYCLES)) begin
        state_n = RX_IDLE;
        tmo_n   = '0;
      end
    end
  end

  assign rx_byte = shift;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder top: break/extended/typematic filtering, scan-code
// translation and the sel strobe that hands each key to the sequencer.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SEL_CYCLES     = 4
) (
  input  logic                clk,
  input  logic                rst,
  ps2_key_decoder_if.master   bus
);

  logic        [7:0]  rx_byte;
  logic               byte_valid;
  logic               frame_err;
  key_lookup_t        lk;

  logic               break_flag;
  logic               last_valid;
  logic        [7:0]  last_byte;
  logic        [10:0] data_reg;
  logic               load_pending;
  logic               sel_reg;
  logic        [7:0]  sel_cnt;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (bus.ps2_clk),
    .ps2_data  (bus.ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  assign lk = key_lookup(rx_byte);

  // data_out is loaded one cycle ahead of sel so it is settled when sel rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      break_flag   <= 1'b0;
      last_valid   <= 1'b0;
      last_byte    <= 8'd0;
      data_reg     <= 11'd0;
      load_pending <= 1'b0;
      sel_reg      <= 1'b0;
      sel_cnt      <= 8'd0;
    end else begin
      if (load_pending) begin
        load_pending <= 1'b0;
        sel_reg      <= 1'b1;
        sel_cnt      <= 8'(SEL_CYCLES);
      end else if (sel_reg) begin
        sel_cnt <= sel_cnt - 8'd1;
        if (sel_cnt == 8'd1) sel_reg <= 1'b0;
      end

      if (byte_valid) begin
        if (rx_byte == SC_EXT) begin
          break_flag <= break_flag;
        end else if (rx_byte == SC_BREAK) begin
          break_flag <= 1'b1;
        end else if (break_flag) begin
          break_flag <= 1'b0;
          if (last_valid && rx_byte == last_byte) last_valid <= 1'b0;
        end else if (last_valid && rx_byte == last_byte) begin
          last_valid <= 1'b1;
        end else if (lk.hit) begin
          last_valid <= 1'b1;
          last_byte  <= rx_byte;
          // A key arriving while a strobe is in flight is dropped, not queued.
          if (!sel_reg && !load_pending) begin
            data_reg     <= lk.code;
            load_pending <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.data_out  = data_reg;
  assign bus.sel       = sel_reg;
  assign bus.frame_err = frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-bangs PS/2 frames and checks the
// resulting strobes, codes, error pulses and timing against hand values.
module tb_ps2_key_decoder;

  localparam int HALF    = 10;
  localparam int TMO     = 2000;
  localparam int SEL_LEN = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   stop_fall_cyc = 0;

  int          pulses = 0;
  int          err_pulses = 0;
  logic [10:0] last_code = 11'd0;
  int          sel_width = 0;
  int          err_width = 0;
  logic        sel_prev = 1'b0;
  logic        err_prev = 1'b0;
  logic [10:0] data_prev = 11'd0;

  int p0;
  int e0;

  ps2_key_decoder_if bus();

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(TMO),
    .SEL_CYCLES    (SEL_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Strobe monitor: latency from the stop-bit edge, data setup and pulse widths.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sel && !sel_prev) begin
        pulses++;
        last_code = bus.data_out;
        sel_width = 1;
        check_output("sel_latency", cyc - stop_fall_cyc, 5);
        check_output("data_before_sel", {21'd0, data_prev}, {21'd0, bus.data_out});
      end else if (bus.sel) begin
        sel_width++;
      end
      if (!bus.sel && sel_prev) check_output("sel_width", sel_width, SEL_LEN);
      if (bus.frame_err && !err_prev) begin
        err_pulses++;
        err_width = 1;
      end else if (bus.frame_err) begin
        err_width++;
      end
      if (!bus.frame_err && err_prev) check_output("err_width", err_width, 1);
    end
    sel_prev  = bus.sel;
    err_prev  = bus.frame_err;
    data_prev = bus.data_out;
  end

  task automatic ps2_bit(input logic b, input bit is_stop);
    repeat (HALF) @(negedge clk);
    bus.ps2_data = b;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
    if (is_stop) stop_fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = bad_par ? (^b) : ~(^b);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit(1'b1, 1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic mark();
    p0 = pulses;
    e0 = err_pulses;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b45;
    rst = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_data_out", {21'd0, bus.data_out}, 0);
    check_output("reset_sel", {31'd0, bus.sel}, 0);
    check_output("reset_frame_err", {31'd0, bus.frame_err}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: press and release '1'
    mark();
    send_frame(8'h16, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h16, 1'b0);
    check_output("t1_pulses", pulses - p0, 1);
    check_output("t1_code", {21'd0, last_code}, 1);
    check_output("t1_held", {21'd0, bus.data_out}, 1);
    check_output("t1_errs", err_pulses - e0, 0);

    // 2: extended Enter press/release, then keypad '/'
    mark();
    send_frame(8'hE0, 1'b0);
    send_frame(8'h5A, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    check_output("t2_enter_pulses", pulses - p0, 1);
    check_output("t2_enter_code", {21'd0, last_code}, 14);
    mark();
    send_frame(8'h4A, 1'b0);
    check_output("t2_div_pulses", pulses - p0, 1);
    check_output("t2_div_code", {21'd0, last_code}, 13);

    // 3: bad parity, then a good frame
    mark();
    send_frame(8'h1E, 1'b1);
    check_output("t3_errs", err_pulses - e0, 1);
    check_output("t3_no_sel", pulses - p0, 0);
    check_output("t3_data_kept", {21'd0, bus.data_out}, 13);
    send_frame(8'h1E, 1'b0);
    check_output("t3_good_pulses", pulses - p0, 1);
    check_output("t3_good_code", {21'd0, last_code}, 2);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1E, 1'b0);

    // 4: typematic repeats are filtered
    mark();
    send_frame(8'h1E, 1'b0);
    send_frame(8'h1E, 1'b0);
    send_frame(8'h1E, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1E, 1'b0);
    send_frame(8'h1E, 1'b0);
    check_output("t4_pulses", pulses - p0, 2);
    check_output("t4_code", {21'd0, last_code}, 2);
    check_output("t4_errs", err_pulses - e0, 0);

    // 5: truncated frame times out silently
    mark();
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    repeat (TMO + 500) @(negedge clk);
    check_output("t5_timeout_errs", err_pulses - e0, 0);
    check_output("t5_timeout_pulses", pulses - p0, 0);
    send_frame(8'h79, 1'b0);
    check_output("t5_pulses", pulses - p0, 1);
    check_output("t5_code", {21'd0, last_code}, 10);
    check_output("t5_errs", err_pulses - e0, 0);

    // 6: reset in the middle of a frame
    b45 = 8'h45;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(b45[i], 1'b0);
    repeat (HALF) @(negedge clk);
    bus.ps2_data = b45[5];
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("t6_rst_sel", {31'd0, bus.sel}, 0);
    check_output("t6_rst_data", {21'd0, bus.data_out}, 0);
    check_output("t6_rst_err", {31'd0, bus.frame_err}, 0);
    repeat (3) @(negedge clk);
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    mark();
    send_frame(8'h7B, 1'b0);
    check_output("t6_pulses", pulses - p0, 1);
    check_output("t6_code", {21'd0, last_code}, 11);
    check_output("t6_errs", err_pulses - e0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
